// File: rtl/pipelined_adder_pkg.sv
// rtl/pipelined_adder_pkg.sv - shared stage control payload and sizing helpers for the pipelined adder
package pipelined_adder_pkg;

    // Narrow per-stage payload; the WIDTH-sized partial sum and operand bits travel beside it.
    typedef struct packed {
        logic carry;
        logic sub;
        logic a_msb;
        logic b_msb;
        logic sat;
        logic ovf;
        logic zero;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_RESET = '0;

    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit width_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipelined_adder_slice.sv
// rtl/pipelined_adder_slice.sv - one registered ripple slice with valid/ready; clamp via PIPELINED_ADDER_SATURATE_EN
module adder_slice
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int S     = 16,
    parameter int IDX   = 0,
    parameter bit LAST  = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [WIDTH-1:0]  up_a,
    input  logic [WIDTH-1:0]  up_b,
    input  logic [WIDTH-1:0]  up_sum,
    input  stage_ctrl_t       up_ctrl,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [WIDTH-1:0]  dn_a,
    output logic [WIDTH-1:0]  dn_b,
    output logic [WIDTH-1:0]  dn_sum,
    output stage_ctrl_t       dn_ctrl
);

    logic [S:0]       slice_res;
    logic [WIDTH-1:0] nxt_sum;
    stage_ctrl_t      nxt_ctrl;
    logic             load;

    assign up_ready = !dn_valid || dn_ready;
    assign load     = up_valid && up_ready;

    always_comb begin
        slice_res = {1'b0, up_a[IDX*S +: S]} + {1'b0, up_b[IDX*S +: S]} + {{S{1'b0}}, up_ctrl.carry};
        nxt_sum   = up_sum;
        nxt_sum[IDX*S +: S] = slice_res[S-1:0];
        nxt_ctrl       = up_ctrl;
        nxt_ctrl.carry = slice_res[S];
        nxt_ctrl.ovf   = 1'b0;
        nxt_ctrl.zero  = 1'b0;
        if (LAST) begin
            // b_msb is already the inverted operand's MSB when subtracting
            nxt_ctrl.ovf = (up_ctrl.a_msb == up_ctrl.b_msb) && (nxt_sum[WIDTH-1] != up_ctrl.a_msb);
`ifdef PIPELINED_ADDER_SATURATE_EN
            if (up_ctrl.sat && nxt_ctrl.ovf) begin
                nxt_sum = up_ctrl.a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            end
`endif
            nxt_ctrl.zero = (nxt_sum == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dn_valid <= 1'b0;
            dn_a     <= '0;
            dn_b     <= '0;
            dn_sum   <= '0;
            dn_ctrl  <= CTRL_RESET;
        end else begin
            if (up_ready) begin
                dn_valid <= up_valid;
            end
            if (load) begin
                dn_a    <= up_a;
                dn_b    <= up_b;
                dn_sum  <= nxt_sum;
                dn_ctrl <= nxt_ctrl;
            end
        end
    end

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - pipelined add/subtract with valid/ready and status flags; sat port via PIPELINED_ADDER_SATURATE_EN
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
`ifdef PIPELINED_ADDER_SATURATE_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int S = slice_width(WIDTH, STAGES);

    if (!width_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
    end

    logic [WIDTH-1:0] b_eff;
    stage_ctrl_t      ctrl_in;

    logic             vld_q [STAGES];
    logic             rdy   [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] sum_q [STAGES];
    stage_ctrl_t      ctrl_q[STAGES];

    assign b_eff = b ^ {WIDTH{sub}};

    always_comb begin
        ctrl_in       = CTRL_RESET;
        ctrl_in.carry = sub;
        ctrl_in.sub   = sub;
        ctrl_in.a_msb = a[WIDTH-1];
        ctrl_in.b_msb = b_eff[WIDTH-1];
`ifdef PIPELINED_ADDER_SATURATE_EN
        ctrl_in.sat   = sat;
`endif
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic             up_valid;
        logic             dn_ready;
        logic [WIDTH-1:0] up_a;
        logic [WIDTH-1:0] up_b;
        logic [WIDTH-1:0] up_sum;
        stage_ctrl_t      up_ctrl;

        if (i == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_a     = a;
            assign up_b     = b_eff;
            assign up_sum   = '0;
            assign up_ctrl  = ctrl_in;
        end else begin : g_body
            assign up_valid = vld_q[i-1];
            assign up_a     = a_q[i-1];
            assign up_b     = b_q[i-1];
            assign up_sum   = sum_q[i-1];
            assign up_ctrl  = ctrl_q[i-1];
        end

        if (i == STAGES - 1) begin : g_tail
            assign dn_ready = out_ready;
        end else begin : g_mid
            assign dn_ready = rdy[i+1];
        end

        adder_slice #(
            .WIDTH (WIDTH),
            .S     (S),
            .IDX   (i),
            .LAST  (i == STAGES - 1)
        ) u_slice (
            .clk      (clk),
            .rst_n    (rst_n),
            .up_valid (up_valid),
            .up_ready (rdy[i]),
            .up_a     (up_a),
            .up_b     (up_b),
            .up_sum   (up_sum),
            .up_ctrl  (up_ctrl),
            .dn_valid (vld_q[i]),
            .dn_ready (dn_ready),
            .dn_a     (a_q[i]),
            .dn_b     (b_q[i]),
            .dn_sum   (sum_q[i]),
            .dn_ctrl  (ctrl_q[i])
        );
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign carry     = ctrl_q[STAGES-1].carry;
    assign overflow  = ctrl_q[STAGES-1].ovf;
    assign zero      = ctrl_q[STAGES-1].zero;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - randomized self-checking bench for pipelined_adder against an arithmetic model
module tb_pipelined_adder;

`ifdef PIPELINED_ADDER_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, sub, sat_in, out_ready;
    logic [31:0] a, b;
    logic        in_ready, out_valid, carry, overflow, zero;
    logic [31:0] sum;

    int checks = 0;
    int errors = 0;

    pipelined_adder #(.WIDTH(32), .STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
`ifdef PIPELINED_ADDER_SATURATE_EN
        .sat       (sat_in),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero)
    );

    localparam int NSW = 4;
    localparam int SW_W [NSW] = '{32, 32, 32, 16};
    localparam int SW_S [NSW] = '{1, 4, 32, 2};

    logic        sw_valid, sw_sub, sw_sat, sw_out_ready;
    logic [31:0] sw_a, sw_b;
    logic        sw_in_ready [NSW];
    logic        sw_out_valid[NSW];
    logic        sw_carry    [NSW];
    logic        sw_ovf      [NSW];
    logic        sw_zero     [NSW];
    logic [31:0] sw_sum      [NSW];

    for (genvar g = 0; g < NSW; g++) begin : g_sw
        localparam int W = SW_W[g];
        logic [W-1:0] s;
        pipelined_adder #(.WIDTH(W), .STAGES(SW_S[g])) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (sw_valid),
            .in_ready  (sw_in_ready[g]),
            .a         (sw_a[W-1:0]),
            .b         (sw_b[W-1:0]),
            .sub       (sw_sub),
`ifdef PIPELINED_ADDER_SATURATE_EN
            .sat       (sw_sat),
`endif
            .out_valid (sw_out_valid[g]),
            .out_ready (sw_out_ready),
            .sum       (s),
            .carry     (sw_carry[g]),
            .overflow  (sw_ovf[g]),
            .zero      (sw_zero[g])
        );
        assign sw_sum[g] = 32'(s);
    end

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        v;
        logic        z;
    } res_t;

    // Plain integer arithmetic: exact signed result decides overflow, unsigned compare decides carry.
    function automatic res_t model(input int w, input logic [31:0] x, input logic [31:0] y,
                                   input logic op, input logic st);
        res_t r;
        longint unsigned mask, ux, uy, full;
        longint sx, sy, ex, smax, smin;
        mask = (64'd1 << w) - 64'd1;
        ux   = longint'(x) & mask;
        uy   = longint'(y) & mask;
        smax = (longint'(1) << (w - 1)) - 1;
        smin = -(longint'(1) << (w - 1));
        sx   = longint'(ux) - (((ux >> (w - 1)) & 1) != 0 ? (longint'(1) << w) : 0);
        sy   = longint'(uy) - (((uy >> (w - 1)) & 1) != 0 ? (longint'(1) << w) : 0);
        ex   = op ? (sx - sy) : (sx + sy);
        full = op ? (ux - uy) : (ux + uy);
        r.s  = 32'(full & mask);
        r.c  = op ? (ux >= uy) : ((ux + uy) > mask);
        r.v  = (ex > smax) || (ex < smin);
        if (st && r.v) r.s = (ex > 0) ? 32'(mask >> 1) : 32'(longint'(1) << (w - 1));
        r.z  = (r.s == 32'd0);
        return r;
    endfunction

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; sat_in = 1'b0; out_ready = 1'b1;
        sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_sub = 1'b0; sw_sat = 1'b0; sw_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
        checks++; if (sum !== 32'd0) begin errors++; $display("FAIL reset_sum got %h expected 00000000", sum); end
        checks++; if ({carry, overflow, zero} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b expected 000", {carry, overflow, zero}); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid got %b expected 0", out_valid); end
        for (int g = 0; g < NSW; g++) begin
            checks++; if (sw_out_valid[g] !== 1'b0) begin errors++; $display("FAIL reset_sweep%0d_out_valid got %b expected 0", g, sw_out_valid[g]); end
        end
    endtask

    task automatic do_op(input string name, input logic [31:0] x, input logic [31:0] y, input logic op,
                         input logic st, input logic [31:0] es, input logic ec, input logic ev, input logic ez);
        @(negedge clk);
        in_valid = 1'b1; a = x; b = y; sub = op; sat_in = st; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready got %b expected 1", name, in_ready); end
        @(negedge clk);
        in_valid = 1'b0; a = $urandom; b = $urandom; sub = $urandom;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_early_valid got %b expected 0", name, out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_latency got out_valid %b expected 1", name, out_valid); end
        checks++; if (sum !== es) begin errors++; $display("FAIL %s_sum got %h expected %h", name, sum, es); end
        checks++; if ({carry, overflow, zero} !== {ec, ev, ez}) begin
            errors++; $display("FAIL %s_flags got cvz=%b expected cvz=%b", name, {carry, overflow, zero}, {ec, ev, ez});
        end
    endtask

    task automatic test_directed();
        do_op("add_small", 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
        do_op("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
`ifdef PIPELINED_ADDER_SATURATE_EN
        do_op("add_sat",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        do_op("sub_sat",   32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
`endif
        do_op("sub_zero",  32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        do_op("sub_borrow",32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        do_op("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] qa[$], qb[$];
        logic        qs[$], qt[$];
        int          sent, got, cyc, inflight;
        logic        stalled, exp_ready;
        logic [31:0] ps;
        logic [2:0]  pf;
        res_t        r;
        sent = 0; got = 0; cyc = 0; inflight = 0; stalled = 1'b0; ps = '0; pf = '0;
        while (got < 8 && cyc < 60) begin
            @(negedge clk);
            out_ready = !(cyc >= 3 && cyc < 7);
            if (sent < 8) begin
                in_valid = 1'b1; a = $urandom; b = $urandom; sub = $urandom; sat_in = $urandom;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stalled) begin
                checks++; if (out_valid !== 1'b1 || sum !== ps || {carry, overflow, zero} !== pf) begin
                    errors++; $display("FAIL b2b_hold cyc %0d got v=%b sum=%h f=%b expected v=1 sum=%h f=%b",
                                       cyc, out_valid, sum, {carry, overflow, zero}, ps, pf);
                end
            end
            exp_ready = !(inflight == 2 && !out_ready);
            checks++; if (in_ready !== exp_ready) begin
                errors++; $display("FAIL b2b_in_ready cyc %0d got %b expected %b", cyc, in_ready, exp_ready);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (qa.size() == 0) begin
                    errors++; $display("FAIL b2b_spurious cyc %0d got out_valid 1 expected 0", cyc);
                end else begin
                    r = model(32, qa.pop_front(), qb.pop_front(), qs.pop_front(), SAT_EN && qt.pop_front());
                    if (sum !== r.s || {carry, overflow, zero} !== {r.c, r.v, r.z}) begin
                        errors++; $display("FAIL b2b_result %0d got sum=%h cvz=%b expected sum=%h cvz=%b",
                                           got, sum, {carry, overflow, zero}, r.s, {r.c, r.v, r.z});
                    end
                    inflight--;
                end
                got++;
            end
            if (in_valid && in_ready) begin
                qa.push_back(a); qb.push_back(b); qs.push_back(sub); qt.push_back(sat_in);
                sent++; inflight++;
            end
            stalled = out_valid && !out_ready;
            ps = sum; pf = {carry, overflow, zero};
            cyc++;
        end
        checks++; if (got != 8) begin errors++; $display("FAIL b2b_timeout got %0d results expected 8", got); end
        drain();
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        in_valid = 1'b1; a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        a = 32'h0000_0009; b = 32'h0000_0004; sub = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_precond got out_valid %b expected 1", out_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b expected 0", out_valid); end
        checks++; if (sum !== 32'd0 || {carry, overflow, zero} !== 3'b000) begin
            errors++; $display("FAIL midrst_outputs got sum=%h cvz=%b expected sum=00000000 cvz=000", sum, {carry, overflow, zero});
        end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b expected 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale cyc %0d got out_valid %b expected 0", k, out_valid); end
        end
    endtask

    task automatic test_sweep();
        logic [31:0] ia[3000], ib[3000];
        bit          iv[3000], isb[3000], ist[3000];
        int          issued, last, idx, m;
        res_t        r;
        issued = 0; last = 0; m = 0;
        sw_out_ready = 1'b1;
        while ((issued < 1000 || m < last + 40) && m < 2900) begin
            @(negedge clk);
            for (int g = 0; g < NSW; g++) begin
                idx = m - SW_S[g];
                checks++;
                if (idx >= 0 && iv[idx]) begin
                    r = model(SW_W[g], ia[idx], ib[idx], isb[idx], SAT_EN && ist[idx]);
                    if (sw_out_valid[g] !== 1'b1 || sw_sum[g] !== r.s ||
                        {sw_carry[g], sw_ovf[g], sw_zero[g]} !== {r.c, r.v, r.z}) begin
                        errors++; $display("FAIL sweep_w%0d_s%0d op %0d got v=%b sum=%h cvz=%b expected v=1 sum=%h cvz=%b",
                                           SW_W[g], SW_S[g], idx, sw_out_valid[g], sw_sum[g],
                                           {sw_carry[g], sw_ovf[g], sw_zero[g]}, r.s, {r.c, r.v, r.z});
                    end
                end else if (sw_out_valid[g] !== 1'b0) begin
                    errors++; $display("FAIL sweep_w%0d_s%0d_bubble cyc %0d got out_valid %b expected 0",
                                       SW_W[g], SW_S[g], m, sw_out_valid[g]);
                end
                checks++; if (sw_in_ready[g] !== 1'b1) begin
                    errors++; $display("FAIL sweep_w%0d_s%0d_in_ready got %b expected 1", SW_W[g], SW_S[g], sw_in_ready[g]);
                end
            end
            iv[m]  = (issued < 1000) && ($urandom_range(3) != 0);
            ia[m]  = $urandom;
            ib[m]  = ($urandom_range(7) == 0) ? ia[m] : $urandom;
            isb[m] = $urandom;
            ist[m] = $urandom;
            sw_valid = iv[m]; sw_a = ia[m]; sw_b = ib[m]; sw_sub = isb[m]; sw_sat = ist[m];
            if (iv[m]) begin
                issued++; last = m;
            end
            m++;
        end
        sw_valid = 1'b0;
        checks++; if (issued != 1000) begin errors++; $display("FAIL sweep_budget got %0d ops expected 1000", issued); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midflight();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined integer add/subtract unit for the 5-stage MIPS datapath.
- Successor to the single-cycle 32-bit combinational adder. Adds configurable width, a configurable ripple-slice pipeline depth, subtract mode and status flags (carry, signed overflow, zero).
- Uses a valid/ready handshake with per-stage backpressure, so EX-stage stalls and bubbles propagate correctly.

Parameters:
- WIDTH, 32, operand and result width in bits; must be divisible by STAGES.
- STAGES, 2, number of pipeline stages (1..WIDTH); each stage resolves one WIDTH/STAGES-bit slice.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands/op present
- in_ready  out  1  stage 0 can accept this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sub  in  1  0: a+b, 1: a-b (a + ~b + 1)
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- carry  out  1  carry-out of MSB; for subtract, 1 means no borrow
- overflow  out  1  signed overflow
- zero  out  1  sum == 0

Behaviour:
- Reset (async assert, sync release):
  - All stage valid bits are 0, so out_valid=0.
  - sum=0, carry=0, overflow=0, zero=0.
  - in_ready=1 after reset.
- Slice width S = WIDTH/STAGES.
- Stage i registers:
  - sum bits [i*S +: S], computed from a, b^{WIDTH{sub}} and the carry from stage i-1 (stage 0 carry-in = sub).
  - The not-yet-consumed upper operand bits and the sub flag, carried forward.
  - Stage 0 also captures the operand MSBs needed for the overflow computation.
- Overflow = (a_msb == b'_msb) && (sum_msb != a_msb), where b' is the inverted operand when sub=1.
- zero is computed in the final stage from the fully assembled sum.
- Latency: exactly STAGES cycles from in_valid&&in_ready to out_valid, with no backpressure. Throughput: 1 result/cycle.
- Handshake:
  - Per-stage ready is ready[i] = !valid[i] || ready[i+1]; ready[STAGES] = out_ready; in_ready = ready[0].
  - A stage loads when its upstream stage is valid and it is ready itself.
  - A stage clears valid when it passes data on and receives none.
  - Bubbles collapse: an empty stage accepts data even while out_ready=0.
- Holding:
  - While out_valid && !out_ready, sum, carry, overflow and zero stay stable.
  - Inputs are sampled only on in_valid&&in_ready.
  - a, b and sub are don't-care when in_valid=0.
- Wrap-around: the sum is modulo 2^WIDTH; carry reports the lost bit.
- Simultaneous accept at input and output on a full pipe: allowed. Every stage shifts and no data is lost or duplicated.
- STAGES=1: single register stage, latency 1; in_ready = !out_valid || out_ready.
- Reset mid-operation: all in-flight results are discarded immediately; no partial result is emitted after reset releases.

Optional Feature:
- Macro: PIPELINED_ADDER_SATURATE_EN.
- Defined:
  - Adds input sat (1 bit), captured with the operands and carried with the data.
  - When sat=1 and overflow=1, sum is clamped: to {1'b0,{WIDTH-1{1'b1}}} if a_msb=0, otherwise to {1'b1,{WIDTH-1{1'b0}}}.
  - overflow still reports 1; zero is evaluated on the clamped value.
  - The clamp adds no extra latency; it is applied in the final stage.
- Undefined: no sat port; sum always wraps.

Decomposition:
- Shared package pipelined_adder_pkg:
  - Stage payload struct (partial sum, remaining operand bits, carry, sub, MSB snapshot, sat).
  - Function slice_width(WIDTH, STAGES).
  - Elaboration check that WIDTH % STAGES == 0.
- Sub-module adder_slice: one registered slice stage with valid/ready, instantiated STAGES times in a generate loop.

Test Plan:
- WIDTH=32, STAGES=2, out_ready=1: a=0x0000_0005, b=0x0000_0003, sub=0 -> 2 cycles later sum=0x8, carry=0, overflow=0, zero=0.
- a=0x7FFF_FFFF, b=1, sub=0 -> sum=0x8000_0000, overflow=1, carry=0. Repeat with the saturate macro defined and sat=1 -> sum=0x7FFF_FFFF, overflow=1.
- a=5, b=5, sub=1 -> sum=0, zero=1, carry=1. Then a=0, b=1, sub=1 -> sum=0xFFFF_FFFF, carry=0, overflow=0.
- Back-to-back stream of 8 random operations, out_ready held 0 for 4 cycles mid-stream:
  - in_ready drops only once both stages are full.
  - Outputs stay stable while stalled.
  - All 8 results arrive in order and match the reference model.
- Assert rst_n=0 for 1 cycle while 2 results are in flight -> out_valid=0 and all outputs 0 immediately; no stale result after release; in_ready=1.
- Sweep STAGES in {1,4,32} with WIDTH=32, plus WIDTH=16/STAGES=2 -> latency equals STAGES, 1000 random operations match the model including carry and overflow.
